dmmu: RTL and testbench

DMMU -- requirements
Module: dmmu

---
 rtl/dmmu.sv | 181 ++++++++++++++++++
 tb/tb_dmmu.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmmu.sv
`default_nettype none
// ============================================================================
// Module   : dmmu
// Summary  : Segmented data MMU with a direct-mapped one-word cache and a posted-write buffer.
// Revision : 1.0
// ============================================================================
module dmmu #(
    parameter int LINES      = 16,
    parameter int WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_data,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [2:0]  d_trd,
    output logic [31:0] d_rd_data,
    output logic        d_miss,
    output logic        d_segfault,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_trd,
    input  logic [31:0] cfg_base,
    input  logic [31:0] cfg_limit,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wr_data,
    input  logic        m_ack,
    input  logic [31:0] m_rd_data
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;

    logic [31:0]      r_base  [8];
    logic [31:0]      r_limit [8];
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag   [LINES];
    logic [31:0]      r_data  [LINES];
    logic [31:0]      r_wb_addr [WBUF_DEPTH];
    logic [31:0]      r_wb_data [WBUF_DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_state, w_next;
    logic [31:0]      r_miss_pa, r_rd_data;

    logic [31:0]      w_pa;
    logic [IDX_W-1:0] w_idx, w_miss_idx;
    logic [TAG_W-1:0] w_tag;
    logic w_access, w_segfault, w_hit, w_full, w_empty;
    logic w_ack, w_deq, w_refill_done, w_idle_ok, w_rd_hit, w_rd_miss, w_enq;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pa       = r_base[d_trd] + d_addr;
    assign w_idx      = w_pa[IDX_W+1:2];
    assign w_tag      = w_pa[31:IDX_W+2];
    assign w_miss_idx = r_miss_pa[IDX_W+1:2];
    assign w_access   = d_rd | d_wr;
    assign w_segfault = w_access && ((d_addr >= r_limit[d_trd]) || (d_addr[1:0] != 2'b00) || (d_rd && d_wr));
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_full     = (r_count == CNT_W'(WBUF_DEPTH));
    assign w_empty    = (r_count == '0);

    // Acks are only meaningful while a transaction is outstanding.
    assign w_ack         = m_ack && m_req;
    assign w_deq         = w_ack && (r_state != S_REFILL);
    assign w_refill_done = w_ack && (r_state == S_REFILL);
    assign w_idle_ok     = (r_state == S_IDLE) && !w_segfault;
    assign w_rd_hit      = w_idle_ok && d_rd && w_hit;
    assign w_rd_miss     = w_idle_ok && d_rd && !w_hit;
    assign w_enq         = w_idle_ok && d_wr && !w_full;
    assign d_segfault    = w_segfault;
    assign d_rd_data     = r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_base[i]  <= '0;
                r_limit[i] <= (i == 0) ? 32'hFFFF_FFFF : 32'h0;
            end
        end else if (cfg_we) begin
            r_base[cfg_trd]  <= cfg_base;
            r_limit[cfg_trd] <= cfg_limit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_rd_miss) w_next = w_empty ? S_REFILL : S_DRAIN;
            S_DRAIN:  if (w_empty || (w_deq && r_count == CNT_W'(1))) w_next = S_REFILL;
            S_REFILL: if (w_refill_done) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_addr    = r_wb_addr[r_head];
        m_wr_data = r_wb_data[r_head];
        d_miss    = 1'b0;
        case (r_state)
            S_IDLE: begin
                m_req  = !w_empty;
                m_we   = !w_empty;
                d_miss = w_access && !w_segfault && ((d_rd && !w_hit) || (d_wr && w_full));
            end
            S_DRAIN: begin
                m_req  = !w_empty;
                m_we   = !w_empty;
                d_miss = w_access && !w_segfault;
            end
            S_REFILL: begin
                m_req  = 1'b1;
                m_addr = r_miss_pa;
                d_miss = w_access && !w_segfault;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= f_inc(r_tail);
            if (w_deq) r_head <= f_inc(r_head);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wb_addr[r_tail] <= w_pa;
            r_wb_data[r_tail] <= d_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                r_valid <= '0;
        else if (w_refill_done) r_valid[w_miss_idx] <= 1'b1;
    end

    // Write hits keep the cached copy coherent; write misses never allocate.
    always_ff @(posedge clk) begin
        if (w_refill_done) begin
            r_tag[w_miss_idx]  <= r_miss_pa[31:IDX_W+2];
            r_data[w_miss_idx] <= m_rd_data;
        end else if (w_enq && w_hit) begin
            r_data[w_idx] <= d_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_miss_pa <= '0;
        end else begin
            if (w_rd_hit)  r_rd_data <= r_data[w_idx];
            if (w_rd_miss) r_miss_pa <= w_pa;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dmmu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmmu
// Summary  : Scoreboard bench for dmmu against an architectural memory/segment model.
// Revision : 1.0
// ============================================================================
module tb_dmmu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_addr, d_wr_data, d_rd_data;
    logic        d_rd, d_wr, d_miss, d_segfault;
    logic [2:0]  d_trd, cfg_trd;
    logic        cfg_we;
    logic [31:0] cfg_base, cfg_limit;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wr_data, m_rd_data;

    dmmu #(.LINES(16), .WBUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
        .d_rd_data(d_rd_data), .d_miss(d_miss), .d_segfault(d_segfault),
        .cfg_we(cfg_we), .cfg_trd(cfg_trd), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wr_data(m_wr_data),
        .m_ack(m_ack), .m_rd_data(m_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_base [8];
    logic [31:0] mdl_lim  [8];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bmem    [logic [31:0]];
    logic [31:0] exp_rd [$];
    logic [63:0] exp_wr [$];
    bit          ack_log [$];
    bit          ack_en;
    int          lat_max;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mdl_base[i] = 32'h0;
            mdl_lim[i]  = (i == 0) ? 32'hFFFF_FFFF : 32'h0;
        end
        exp_rd.delete();
        exp_wr.delete();
    endtask

    // Backing memory: random-latency single-cycle ack pulses, checks write order.
    initial begin
        int wait_cnt;
        logic [63:0] e;
        m_ack = 1'b0;
        m_rd_data = '0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (rst) wait_cnt = 0;
            else if (m_req && ack_en) begin
                if (wait_cnt > 0) wait_cnt--;
                else begin
                    m_ack = 1'b1;
                    ack_log.push_back(m_we);
                    if (m_we) begin
                        if (exp_wr.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL wr_unexpected actual=%h required=none", m_addr);
                        end else begin
                            e = exp_wr.pop_front();
                            chk("wr_addr", m_addr, e[63:32]);
                            chk("wr_data", m_wr_data, e[31:0]);
                        end
                        bmem[m_addr] = m_wr_data;
                    end else begin
                        m_rd_data = bmem.exists(m_addr) ? bmem[m_addr] : init_val(m_addr);
                    end
                    wait_cnt = $urandom_range(0, lat_max);
                end
            end
        end
    end

    // Read-data monitor: one cycle after an accepted read hit.
    initial begin
        bit pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual=%h required=none", d_rd_data);
                end else chk("rd_data", d_rd_data, exp_rd.pop_front());
            end
            pend = !rst && d_rd && !d_wr && !d_miss && !d_segfault;
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [2:0] trd,
                          input logic [31:0] addr, input logic [31:0] wdata, output bit first_miss);
        bit sf, done;
        logic [31:0] pa;
        int n;
        sf = (rd && wr) || (addr[1:0] != 2'b00) || (addr >= mdl_lim[trd]);
        pa = mdl_base[trd] + addr;
        @(posedge clk); #1;
        d_rd = rd; d_wr = wr; d_trd = trd; d_addr = addr; d_wr_data = wdata;
        first_miss = 1'b0;
        done = 1'b0;
        n = 0;
        while (!done) begin
            @(negedge clk);
            if (n == 0) begin
                chk("segfault", d_segfault, sf);
                first_miss = d_miss;
            end
            if (sf || d_segfault) begin
                chk("miss_on_segfault", d_miss, 0);
                done = 1'b1;
            end else if (!d_miss) begin
                if (wr) begin
                    exp_wr.push_back({pa, wdata});
                    ref_mem[pa] = wdata;
                end else exp_rd.push_back(ref_rd(pa));
                done = 1'b1;
            end else if (n >= 300) begin
                checks++;
                errors++;
                $display("FAIL access_timeout actual=%0d required=<300", n);
                done = 1'b1;
            end
            n++;
        end
        @(posedge clk); #1;
        d_rd = 1'b0; d_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (m_req && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_req) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=%0d required=<2000", n);
        end
    endtask

    task automatic cfg(input logic [2:0] trd, input logic [31:0] base, input logic [31:0] lim);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_trd = trd; cfg_base = base; cfg_limit = lim;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mdl_base[trd] = base;
        mdl_lim[trd]  = lim;
    endtask

    task automatic drive1(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        d_rd = rd; d_wr = wr; d_trd = 3'd0; d_addr = addr; d_wr_data = wdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fm;
        logic [31:0] a;
        int op;
        rst = 1'b1; ack_en = 1'b1; lat_max = 2;
        d_rd = 0; d_wr = 0; d_trd = 0; d_addr = 0; d_wr_data = 0;
        cfg_we = 0; cfg_trd = 0; cfg_base = 0; cfg_limit = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rd_data", d_rd_data, 0);
        chk("reset_m_req", m_req, 0);
        chk("reset_m_we", m_we, 0);
        access(1, 0, 3'd1, 32'h0, 32'h0, fm);

        // Refill of a cold line, then a hit on replay.
        bmem[32'h40] = 32'hDEAD_BEEF;
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        access(1, 0, 3'd0, 32'h40, 32'h0, fm);
        chk("cold_read_miss", fm, 1);
        chk("hit_data", d_rd_data, 32'hDEAD_BEEF);

        // Segment bounds and relocation.
        cfg(3'd3, 32'h1000, 32'h100);
        wait_idle();
        access(1, 0, 3'd3, 32'h100, 32'h0, fm);
        @(negedge clk);
        chk("segfault_no_req", m_req, 0);
        ack_en = 1'b0;
        @(posedge clk); #1;
        d_rd = 1; d_trd = 3'd3; d_addr = 32'h0FC;
        @(negedge clk);
        chk("reloc_miss", d_miss, 1);
        @(posedge clk); #1 d_rd = 0;
        @(negedge clk);
        chk("refill_req", m_req, 1);
        chk("refill_we", m_we, 0);
        chk("refill_addr", m_addr, 32'h10FC);
        ack_en = 1'b1;
        access(1, 0, 3'd3, 32'h0FC, 32'h0, fm);

        // Write buffer fills, fifth write must retry, drain in order.
        wait_idle();
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            access(0, 1, 3'd0, 32'h200 + 32'(i * 4), $urandom, fm);
            chk("wbuf_accept", fm, 0);
        end
        drive1(0, 1, 32'h210, 32'h1234_5678);
        @(negedge clk);
        chk("wbuf_full_miss", d_miss, 1);
        @(posedge clk); #1 d_wr = 0;
        ack_log.delete();
        ack_en = 1'b1;
        wait_idle();
        chk("drain_count", ack_log.size(), 4);
        chk("drain_empty", exp_wr.size(), 0);

        // Read miss drains buffered writes before the refill.
        ack_en = 1'b0;
        access(0, 1, 3'd0, 32'h300, 32'hCAFE_0300, fm);
        access(0, 1, 3'd0, 32'h304, 32'hCAFE_0304, fm);
        ack_log.delete();
        drive1(1, 0, 32'h300, 32'h0);
        @(negedge clk);
        chk("raw_read_miss", d_miss, 1);
        @(posedge clk); #1 d_rd = 0;
        ack_en = 1'b1;
        access(1, 0, 3'd0, 32'h300, 32'h0, fm);
        chk("order_len", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            chk("order_0_we", ack_log[0], 1);
            chk("order_1_we", ack_log[1], 1);
            chk("order_2_we", ack_log[2], 0);
        end

        // Reset in the middle of a refill abandons it.
        wait_idle();
        ack_en = 1'b0;
        drive1(1, 0, 32'h500, 32'h0);
        @(negedge clk);
        chk("pre_rst_miss", d_miss, 1);
        @(posedge clk); #1 d_rd = 0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_m_req", m_req, 0);
        chk("rst_rd_data", d_rd_data, 0);
        ack_en = 1'b1;
        access(1, 0, 3'd0, 32'h500, 32'h0, fm);
        chk("post_rst_miss", fm, 1);

        // Illegal combinations.
        access(1, 1, 3'd0, 32'h40, 32'h0, fm);
        access(1, 0, 3'd0, 32'h42, 32'h0, fm);

        // Randomized traffic across overlapping and wrapping segments.
        cfg(3'd1, 32'h2000, 32'h400);
        cfg(3'd2, 32'h0, 32'h80);
        cfg(3'd3, 32'hFFFF_FF00, 32'h200);
        lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            a = $urandom_range(0, 32'h13F) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) a = a | 32'h1;
            op = $urandom_range(0, 15);
            if (op == 0)      access(1, 1, 3'($urandom_range(0, 3)), a, $urandom, fm);
            else if (op < 8)  access(1, 0, 3'($urandom_range(0, 3)), a, 32'h0, fm);
            else              access(0, 1, 3'($urandom_range(0, 3)), a, $urandom, fm);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("final_rd_queue", exp_rd.size(), 0);
        chk("final_wr_queue", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
